// File: rtl/wc_tile_feeder.sv
// Producer side of the Winograd F(6,4) core: packs a serial sample stream into
// overlapping N-sample tiles (stride M) with zero-padding at the end of each row.
module wc_tile_feeder #(
   parameter int W = 10,
   parameter int N = 9,
   parameter int M = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   input  logic           in_last,
   output logic           in_ready,
   output logic [N*W-1:0] D,
   output logic           tile_valid,
   input  logic           tile_ready,
   output logic           tile_last,
   output logic [3:0]     tile_fill
);

   typedef enum logic {FILL, HOLD} state_t;

   localparam logic [3:0]  LAST_SLOT = 4'(N - 1);
   localparam int unsigned OVL       = N - M;

   state_t       state, state_nx;
   logic         run;
   logic [3:0]   cnt;
   logic [W-1:0] tbuf [N];
   logic         tlast;
   logic [3:0]   tfill;
   logic         accept;
   logic         close;

   always_ff @(posedge clk) begin
      if (!rst) state <= FILL;
      else      state <= state_nx;
   end

   // run keeps in_ready low for the reset cycle even though state is already FILL
   always_comb begin
      state_nx   = state;
      in_ready   = (state == FILL) && run;
      tile_valid = (state == HOLD);
      accept     = in_valid && in_ready;
      close      = accept && ((cnt == LAST_SLOT) || in_last);
      case (state)
         FILL: if (close)      state_nx = HOLD;
         HOLD: if (tile_ready) state_nx = FILL;
         default:              state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         run   <= 1'b0;
         cnt   <= '0;
         tlast <= 1'b0;
         tfill <= '0;
         for (int unsigned k = 0; k < N; k++) tbuf[k] <= '0;
      end else begin
         run <= 1'b1;
         if (accept) begin
            tbuf[cnt] <= in_data;
            cnt       <= cnt + 4'd1;
            if (close) begin
               tfill <= cnt + 4'd1;
               tlast <= in_last;
            end
         end else if (state == HOLD && tile_ready) begin
            // carry the trailing overlap forward unless the row just ended
            for (int unsigned k = 0; k < N; k++)
               tbuf[k] <= (!tlast && k < OVL) ? tbuf[(k + M) % N] : '0;
            cnt   <= tlast ? 4'd0 : 4'(OVL);
            tlast <= 1'b0;
            tfill <= '0;
         end
      end
   end

   always_comb begin
      D = '0;
      for (int unsigned k = 0; k < N; k++) D[N*W-1-k*W -: W] = tbuf[k];
   end

   assign tile_last = tlast;
   assign tile_fill = tfill;

endmodule
